// File: rtl/tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_arbiter : round-robin launcher sharing one serial frame transmitter
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  input  logic [N_REQ-1:0]          parity_en_in,
  input  logic                      tx_done,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_last;
  logic [TMR_W-1:0]  r_timer;

  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W:0]     w_sum;

  // Search last+1, last+2, ... with wrap; first requester found wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_sum = {1'b0, r_last} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      if (!w_found && req[w_sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= ID_W'(N_REQ-1);
      r_timer   <= '0;
      ack       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      tx_parity <= 1'b0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
            tx_data   <= data_in[w_winner*DATA_W +: DATA_W];
            tx_parity <= parity_en_in[w_winner];
            grant_id  <= w_winner;
            r_last    <= w_winner;
            busy      <= 1'b1;
            r_state   <= S_LAUNCH;
          end
        end
        // LAUNCH spans the ack cycle and the tx_start cycle; tx_done is
        // ignored in both, and the timer starts with the first wait cycle.
        S_LAUNCH: begin
          if (!tx_start) begin
            tx_start <= 1'b1;
          end else begin
            r_timer <= '0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_timer == TMR_W'(TIMEOUT-1)) begin
            busy    <= 1'b0;
            err     <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin scheduler that shares the single serial frame transmitter among `N_REQ` requesters. It accepts one byte at a time from the winning requester, latches the payload and the per-frame parity choice, and launches the transmitter with a one-cycle start pulse. It then holds the transmitter busy until it reports frame completion, with a watchdog that recovers the arbiter if completion never arrives. It sits between the client blocks and the Tx frame FSM/datapath.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 8: payload width per frame; must equal the transmitter message size.
- `TIMEOUT`, 1024: maximum WAIT_DONE cycles before abort (≥2).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  level request per requester.
- `data_in`  in  N_REQ*DATA_W  requester i payload at bits [i*DATA_W +: DATA_W].
- `parity_en_in`  in  N_REQ  requester i wants a parity bit on its frame.
- `tx_done`  in  1  one-cycle pulse from the transmitter when its frame ends.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: payload of that requester captured.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  latched payload, stable from ack until the next grant.
- `tx_parity`  out  1  latched parity enable, stable alongside `tx_data`.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `busy`  out  1  high from the grant cycle until return to IDLE.
- `err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE: if any `req` bit is high at the edge, select the winner by searching `last+1, last+2, …` mod N_REQ (wrap-around). On the same edge: latch `tx_data`, `tx_parity`, `grant_id`; set `last` = winner; assert `ack[winner]` and `busy`; go to LAUNCH. If no `req` bit is high, stay in IDLE.
- LAUNCH: `tx_start`=1 for exactly this cycle, timer cleared to 0, next state WAIT_DONE.
- WAIT_DONE: on `tx_done`, go to IDLE and drop `busy`. Otherwise increment the timer. When the timer reaches TIMEOUT-1 without `tx_done`, go to IDLE, drop `busy`, and pulse `err` for one cycle.
- Timer width is $clog2(TIMEOUT). The timer never wraps, because the state exits at TIMEOUT-1.
- `tx_done` and timer expiry in the same cycle: completion wins and `err` stays 0.
- `tx_done` outside WAIT_DONE is ignored, including a pulse during LAUNCH.
- Requests are not sticky. A requester must hold `req` and its data until it sees `ack`. A request dropped before grant is never served.
- The winner's `req` may stay high after `ack`. It is then treated as a new request and competes again at the next IDLE, with lowest priority.
- `tx_data`, `tx_parity` and `grant_id` change only on a grant edge.

## Timing
- Reset (`rst_n`=0 at an edge) takes effect at that edge:
  - state IDLE, `last`=N_REQ-1 (requester 0 has top priority), timer 0.
  - All outputs 0: `ack`, `tx_start`, `tx_data`, `tx_parity`, `grant_id`, `busy`, `err`.
- Reset mid-frame aborts silently: no `err`, no `ack`.
- Request sampled in IDLE at edge k: `ack` and `busy` high in cycle k+1, `tx_start` high in cycle k+2, WAIT_DONE from cycle k+3.
- `tx_done` sampled at edge m: `busy`=0 from cycle m+1 (IDLE). The earliest next `ack` is cycle m+2, so back-to-back frames are separated by one IDLE cycle.
- Timeout: with no `tx_done`, `err`=1 and `busy`=0 in the cycle after the TIMEOUT-th WAIT_DONE cycle.

## Test plan
Parameters for all scenarios: N_REQ=4, DATA_W=8, TIMEOUT=16.
- Single request: `req`=0001, `data_in[7:0]`=0xA5, `parity_en_in[0]`=1 → `ack`=0001 one cycle later, `tx_start` the next cycle, `tx_data`=0xA5, `tx_parity`=1, `grant_id`=0. Then `tx_done` pulse → `busy` low the next cycle.
- Fairness: `req`=1111 held, with `tx_done` returned 5 cycles after each `tx_start` → grants 0,1,2,3,0. Each `ack` is one-hot and one cycle wide, and `tx_data` tracks the winner's payload.
- Wrap: `req`=0101 held, after reset → grants 0,2,0,2. With `req`=1001 after a grant to 3 → next grant is 0.
- Watchdog: grant to requester 1, `tx_done` withheld → `err` pulses exactly 16 cycles after the first WAIT_DONE cycle, with `busy`=0. A following `req`=0100 is then granted normally.
- Reset mid-frame: `rst_n`=0 during WAIT_DONE → all outputs 0 after the edge, `err`=0. Afterwards `req`=1010 → grant to 1, not 3.
- Edge events:
  - `tx_done` pulsed in IDLE and in LAUNCH → no state change.
  - `tx_done` on the timer's TIMEOUT-1 cycle → normal completion, `err`=0.
  - `req` dropped one cycle before its expected grant → requester not acked.
